timestamp_extract: RTL and testbench

- Receive-side counterpart of the sync-packet timestamp injector.
- Taps an AXI-stream at the far end of the path. On the first beat of a sync packet it captures the timestamp slot region and the local tick.
- It then walks the slots and emits one record per filled slot on a valid/ready record interface: hop index, nb_sync, remote tick, and one-way latency against the local tick.
- Sits beside packet_detect in the receive datapath. It is passive and never back-pressures the stream.

---
 rtl/timestamp_pkg.sv | 15 +
 rtl/timestamp_extract.sv | 112 +++++++++++
 tb/tb_timestamp_extract.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/timestamp_pkg.sv
// timestamp_pkg: shared sync-packet timestamp slot layout, constants and FSM states
package timestamp_pkg;
    localparam int BYTE = 8;
    localparam int PAYLOAD_OFFSET = (6 + 6 + 2 + 2 + 2) * BYTE;
    localparam int TIMESTAMP_SIZE = 96;
    localparam logic [31:0] EMPTY_TIMESTAMP = 32'hDEADBEEF;
    typedef struct packed {
        logic [31:0] nb_sync;
        logic [63:0] tick;
    } ts_slot_t;
    typedef enum logic [1:0] {TS_IDLE, TS_SCAN, TS_EMIT} ts_state_e;
    function automatic logic slot_empty(input ts_slot_t s);
        return s.tick[31:0] == EMPTY_TIMESTAMP;
    endfunction
endpackage

// File: rtl/timestamp_extract.sv
// timestamp_extract: passive rx tap that turns sync-packet timestamp slots into per-hop latency records
// Ports: axis_aclk/axil_aresetn clock and async active-low reset; i_axis_* observed stream (never
// back-pressured); i_sync_detected first-beat sync flag; i_curr_tick local tick; o_rec_* valid/ready
// record (hop, nb_sync, remote tick, latency, last); o_busy extraction active; o_pkt_cnt/o_drop_cnt
// live only when TIMESTAMP_EXTRACT_STATS_EN is defined, otherwise tied to 0.
module timestamp_extract
    import timestamp_pkg::*;
#(
    parameter int MAX_SLOTS = 3,
    parameter int TDATA_W = 512,
    localparam int HW = MAX_SLOTS > 1 ? $clog2(MAX_SLOTS) : 1
) (
    input  logic               axis_aclk,
    input  logic               axil_aresetn,
    input  logic               i_axis_tvalid,
    input  logic               i_axis_tready,
    input  logic [TDATA_W-1:0] i_axis_tdata,
    input  logic               i_axis_tlast,
    input  logic               i_sync_detected,
    input  logic [63:0]        i_curr_tick,
    output logic               o_rec_valid,
    input  logic               i_rec_ready,
    output logic [HW-1:0]      o_rec_hop,
    output logic [31:0]        o_rec_nb_sync,
    output logic [63:0]        o_rec_tick,
    output logic [63:0]        o_rec_latency,
    output logic               o_rec_last,
    output logic               o_busy,
    output logic [15:0]        o_pkt_cnt,
    output logic [15:0]        o_drop_cnt
);
    ts_state_e state;
    ts_slot_t slot_q [MAX_SLOTS];
    logic [63:0] rx_tick_q;
    logic [HW-1:0] k;
    logic sof, hs, trig, last_c;
    logic unused_tdata;
    assign unused_tdata = ^i_axis_tdata;
    assign hs = i_axis_tvalid & i_axis_tready;
    assign trig = hs & sof & i_sync_detected;
    assign o_busy = state != TS_IDLE;
    // last means no filled slot remains above the one being emitted
    always_comb begin
        last_c = 1'b1;
        for (int i = 0; i < MAX_SLOTS; i++)
            if (i > int'(k) && !slot_empty(slot_q[i])) last_c = 1'b0;
    end
    always_ff @(posedge axis_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            state <= TS_IDLE;
            sof <= 1'b1;
            k <= '0;
            rx_tick_q <= '0;
            for (int i = 0; i < MAX_SLOTS; i++) slot_q[i] <= '0;
            o_rec_valid <= 1'b0;
            o_rec_hop <= '0;
            o_rec_nb_sync <= '0;
            o_rec_tick <= '0;
            o_rec_latency <= '0;
            o_rec_last <= 1'b0;
        end else begin
            if (hs) sof <= i_axis_tlast;
            case (state)
                TS_IDLE: if (trig) begin
                    for (int i = 0; i < MAX_SLOTS; i++)
                        slot_q[i] <= i_axis_tdata[PAYLOAD_OFFSET + TIMESTAMP_SIZE * i +: TIMESTAMP_SIZE];
                    rx_tick_q <= i_curr_tick;
                    k <= '0;
                    state <= TS_SCAN;
                end
                TS_SCAN: if (slot_empty(slot_q[k])) begin
                    if (k == HW'(MAX_SLOTS - 1)) state <= TS_IDLE;
                    else k <= k + HW'(1);
                end else begin
                    o_rec_valid <= 1'b1;
                    o_rec_hop <= k;
                    o_rec_nb_sync <= slot_q[k].nb_sync;
                    o_rec_tick <= slot_q[k].tick;
                    o_rec_latency <= rx_tick_q - slot_q[k].tick;
                    o_rec_last <= last_c;
                    state <= TS_EMIT;
                end
                TS_EMIT: if (i_rec_ready) begin
                    o_rec_valid <= 1'b0;
                    if (o_rec_last) state <= TS_IDLE;
                    else begin
                        k <= k + HW'(1);
                        state <= TS_SCAN;
                    end
                end
                default: state <= TS_IDLE;
            endcase
        end
    end
`ifdef TIMESTAMP_EXTRACT_STATS_EN
    logic [15:0] pkt_cnt, drop_cnt;
    always_ff @(posedge axis_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            pkt_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (trig && state == TS_IDLE && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
            if (trig && state != TS_IDLE && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
    assign o_pkt_cnt = pkt_cnt;
    assign o_drop_cnt = drop_cnt;
`else
    assign o_pkt_cnt = '0;
    assign o_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_timestamp_extract.sv
// tb_timestamp_extract: scoreboard bench for timestamp_extract record extraction, drops and reset
module tb_timestamp_extract;
    localparam bit STATS =
`ifdef TIMESTAMP_EXTRACT_STATS_EN
        1'b1;
`else
        1'b0;
`endif
    localparam logic [95:0] E = {32'h0, 64'h0000_0000_DEAD_BEEF};
    typedef struct packed {
        logic [1:0]  hop;
        logic [31:0] nb;
        logic [63:0] tick;
        logic [63:0] lat;
        logic        last;
    } rec_t;
    logic clk = 0, axil_aresetn = 0;
    logic i_axis_tvalid = 0, i_axis_tready = 0, i_axis_tlast = 0, i_sync_detected = 0, i_rec_ready = 0;
    logic [511:0] i_axis_tdata = '0;
    logic [63:0] i_curr_tick = '0;
    logic o_rec_valid, o_rec_last, o_busy;
    logic [1:0] o_rec_hop;
    logic [31:0] o_rec_nb_sync;
    logic [63:0] o_rec_tick, o_rec_latency;
    logic [15:0] o_pkt_cnt, o_drop_cnt;
    rec_t q[$];
    rec_t act;
    int checks = 0, errors = 0;
    int n;
    always #5 clk = ~clk;
    timestamp_extract dut (
        .axis_aclk(clk), .axil_aresetn(axil_aresetn),
        .i_axis_tvalid(i_axis_tvalid), .i_axis_tready(i_axis_tready), .i_axis_tdata(i_axis_tdata),
        .i_axis_tlast(i_axis_tlast), .i_sync_detected(i_sync_detected), .i_curr_tick(i_curr_tick),
        .o_rec_valid(o_rec_valid), .i_rec_ready(i_rec_ready), .o_rec_hop(o_rec_hop),
        .o_rec_nb_sync(o_rec_nb_sync), .o_rec_tick(o_rec_tick), .o_rec_latency(o_rec_latency),
        .o_rec_last(o_rec_last), .o_busy(o_busy), .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt)
    );
    assign act = {o_rec_hop, o_rec_nb_sync, o_rec_tick, o_rec_latency, o_rec_last};
    // every valid cycle is compared against the queue head, so stalled records must hold steady
    always @(negedge clk) if (axil_aresetn && o_rec_valid) begin
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL rec_unexpected: got %h, no record expected", act);
        end else begin
            if (act !== q[0]) begin
                errors++;
                $display("FAIL rec: got %h expected %h", act, q[0]);
            end
            if (i_rec_ready) void'(q.pop_front());
        end
    end
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    function automatic logic [511:0] mk(input logic [95:0] s0, input logic [95:0] s1, input logic [95:0] s2);
        logic [511:0] d;
        d = '0;
        d[144 +: 96] = s0;
        d[240 +: 96] = s1;
        d[336 +: 96] = s2;
        return d;
    endfunction
    task automatic beat(input logic [511:0] d, input logic last, input logic sync);
        i_axis_tvalid = 1; i_axis_tready = 1; i_axis_tdata = d; i_axis_tlast = last; i_sync_detected = sync;
        @(posedge clk); #1;
        i_axis_tvalid = 0; i_sync_detected = 0;
    endtask
    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!o_rec_valid && cnt < 50);
    endtask
    task automatic wait_idle();
        int c = 0;
        do begin @(negedge clk); c++; end while (o_busy && c < 100);
        if (o_busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(o_rec_valid), 0);
        check("rst_busy", 64'(o_busy), 0);
        check("rst_latency", o_rec_latency, 0);
        check("rst_pkt", 64'(o_pkt_cnt), 0);
        axil_aresetn = 1;
        @(posedge clk); #1;
        // two filled slots, ready held high
        i_rec_ready = 1; i_curr_tick = 64'd1000;
        q.push_back('{0, 32'd5, 64'd100, 64'd900, 1'b0});
        q.push_back('{1, 32'd6, 64'd200, 64'd800, 1'b1});
        beat(mk({32'd5, 64'd100}, {32'd6, 64'd200}, E), 1, 1);
        wait_valid(n);
        check("t1_first_valid", 64'(n), 2);
        wait_idle();
        check("t1_pkt", 64'(o_pkt_cnt), STATS ? 1 : 0);
        // wrapped remote tick in the last slot
        i_curr_tick = 64'h10;
        q.push_back('{2, 32'd7, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b1});
        beat(mk(E, E, {32'd7, 64'hFFFF_FFFF_FFFF_FFF0}), 1, 1);
        wait_valid(n);
        check("t2_first_valid", 64'(n), 4);
        wait_idle();
        // all slots empty
        beat(mk(E, E, E), 1, 1);
        n = 0;
        repeat (10) begin @(negedge clk); if (o_busy) n++; end
        check("t3_busy_cycles", 64'(n), 3);
        check("t3_pkt", 64'(o_pkt_cnt), STATS ? 3 : 0);
        // drop while stalled in EMIT
        @(posedge clk); #1;
        i_rec_ready = 0; i_curr_tick = 64'd50;
        q.push_back('{0, 32'd1, 64'd10, 64'd40, 1'b0});
        q.push_back('{1, 32'd2, 64'd20, 64'd30, 1'b1});
        beat(mk({32'd1, 64'd10}, {32'd2, 64'd20}, E), 1, 1);
        wait_valid(n);
        check("t4_first_valid", 64'(n), 2);
        @(posedge clk); #1;
        i_curr_tick = 64'd9999;
        beat(mk({32'd8, 64'd1}, E, E), 1, 1);
        repeat (20) @(negedge clk);
        check("t4_drop", 64'(o_drop_cnt), STATS ? 1 : 0);
        @(posedge clk); #1;
        i_rec_ready = 1;
        wait_idle();
        check("t4_pkt", 64'(o_pkt_cnt), STATS ? 4 : 0);
        check("t4_q_empty", 64'(q.size()), 0);
        // sync flag on a non-first beat must not trigger
        @(posedge clk); #1;
        beat(mk(E, E, E), 0, 0);
        beat(mk({32'd3, 64'd3}, E, E), 1, 1);
        repeat (5) @(negedge clk);
        check("t5_busy", 64'(o_busy), 0);
        check("t5_pkt", 64'(o_pkt_cnt), STATS ? 4 : 0);
        // async reset during EMIT
        @(posedge clk); #1;
        i_rec_ready = 0; i_curr_tick = 64'd2;
        q.push_back('{0, 32'd3, 64'd1, 64'd1, 1'b1});
        beat(mk({32'd3, 64'd1}, E, E), 1, 1);
        wait_valid(n);
        @(posedge clk); #2;
        axil_aresetn = 0;
        q.delete();
        #1;
        check("t6_valid_async", 64'(o_rec_valid), 0);
        check("t6_busy", 64'(o_busy), 0);
        check("t6_pkt", 64'(o_pkt_cnt), 0);
        check("t6_drop", 64'(o_drop_cnt), 0);
        @(posedge clk); #1;
        axil_aresetn = 1; i_rec_ready = 1; i_curr_tick = 64'd15;
        @(posedge clk); #1;
        q.push_back('{0, 32'd9, 64'd5, 64'd10, 1'b1});
        beat(mk({32'd9, 64'd5}, E, E), 1, 1);
        wait_valid(n);
        check("t6_first_valid", 64'(n), 2);
        wait_idle();
        check("t6_pkt_after", 64'(o_pkt_cnt), STATS ? 1 : 0);
        check("final_q_empty", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
